// File: rtl/parity_ctrl_pkg.sv
// Shared types and the parity verdict helper for the parity frame controller.
package parity_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, REPORT} ctrl_state_t;
    typedef enum logic {EVEN, ODD} par_state_t;

    // Mismatch when data ones plus the parity bit disagree with the scheme.
    function automatic logic parity_err(input logic odd, input logic pbit, input logic odd_mode);
        return odd ^ pbit ^ odd_mode;
    endfunction

endpackage

// File: rtl/parity_bit_tracker.sv
// Two-state serial parity tracker: toggles on every enabled 1 bit.
module parity_bit_tracker
    import parity_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic odd
);

    par_state_t r_state;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            r_state <= EVEN;
        end else if (en && bit_in) begin
            r_state <= (r_state == EVEN) ? ODD : EVEN;
        end
    end

    assign odd = (r_state == ODD);

endmodule

// File: rtl/parity_frame_ctrl.sv
// Accepts a word plus parity bit, serializes it LSB-first through the tracker,
// and returns a parity verdict over valid/ready with a saturating error count.
module parity_frame_ctrl
    import parity_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ODD_MODE = 0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              clr_cnt,
    output logic              busy
);

    localparam int unsigned BCNT_W = $clog2(DATA_W + 1);

    ctrl_state_t       r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [BCNT_W-1:0] r_bit_cnt;
    logic              r_cap_par;
    logic              r_out_valid;
    logic              r_out_err;
    logic              r_in_ready;
    logic              r_busy;
    logic [CNT_W-1:0]  r_err_cnt;

    logic w_accept;
    logic w_trk_en;
    logic w_trk_odd;
    logic w_err;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_trk_en = (r_state == SHIFT);
    assign w_err    = parity_err(w_trk_odd, r_cap_par, 1'(ODD_MODE));

    parity_bit_tracker u_tracker (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (w_accept),
        .en     (w_trk_en),
        .bit_in (r_shreg[0]),
        .odd    (w_trk_odd)
    );

    // Controller FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_cap_par   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shreg    <= in_data;
                        r_cap_par  <= in_parity;
                        r_bit_cnt  <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shreg   <= r_shreg >> 1;
                    r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
                    if (r_bit_cnt == BCNT_W'(DATA_W - 1)) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    r_out_err   <= w_err;
                    r_out_valid <= 1'b1;
                    r_state     <= REPORT;
                end
                REPORT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Saturating error counter; a clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (!rstn || clr_cnt) begin
            r_err_cnt <= '0;
        end else if ((r_state == CHECK) && w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_err   = r_out_err;
    assign err_cnt   = r_err_cnt;
    assign busy      = r_busy;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed bench for parity_frame_ctrl: even, odd-mode and 2-bit-counter builds share stimulus.
module tb_parity_frame_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_parity;
    logic       out_ready;
    logic       clr_cnt;

    logic       ev_in_ready, ev_out_valid, ev_out_err, ev_busy;
    logic [7:0] ev_err_cnt;
    logic       od_in_ready, od_out_valid, od_out_err, od_busy;
    logic [7:0] od_err_cnt;
    logic       sat_in_ready, sat_out_valid, sat_out_err, sat_busy;
    logic [1:0] sat_err_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int acc_q[$];
    logic vrd_q[$];

    always #5 clk = ~clk;

    parity_frame_ctrl #(.DATA_W(8), .ODD_MODE(0), .CNT_W(8)) u_even (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ev_in_ready),
        .in_data(in_data), .in_parity(in_parity), .out_valid(ev_out_valid),
        .out_ready(out_ready), .out_err(ev_out_err), .err_cnt(ev_err_cnt),
        .clr_cnt(clr_cnt), .busy(ev_busy)
    );

    parity_frame_ctrl #(.DATA_W(8), .ODD_MODE(1), .CNT_W(8)) u_odd (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(od_in_ready),
        .in_data(in_data), .in_parity(in_parity), .out_valid(od_out_valid),
        .out_ready(out_ready), .out_err(od_out_err), .err_cnt(od_err_cnt),
        .clr_cnt(clr_cnt), .busy(od_busy)
    );

    parity_frame_ctrl #(.DATA_W(8), .ODD_MODE(0), .CNT_W(2)) u_sat (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_data(in_data), .in_parity(in_parity), .out_valid(sat_out_valid),
        .out_ready(out_ready), .out_err(sat_out_err), .err_cnt(sat_err_cnt),
        .clr_cnt(clr_cnt), .busy(sat_busy)
    );

    // Cycle stamp of every accept and the verdict of every handshake on the even build.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && ev_in_ready) acc_q.push_back(cyc);
        if (ev_out_valid && out_ready) vrd_q.push_back(ev_out_err);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one word for a single accept edge, then wait for the verdict.
    task automatic send(input logic [7:0] d, input logic p, output int lat);
        in_data   = d;
        in_parity = p;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!ev_out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!ev_out_valid) chk("send_timeout", 32'(ev_out_valid), 32'd1);
    endtask

    initial begin
        int lat;
        int t;
        logic [7:0] w[3];
        logic       wp[3];
        w  = '{8'hFF, 8'h01, 8'h80};
        wp = '{1'b0, 1'b0, 1'b1};

        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_parity = 1'b0;
        out_ready = 1'b1; clr_cnt = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        chk("rst_in_ready",  32'(ev_in_ready),  32'd1);
        chk("rst_out_valid", 32'(ev_out_valid), 32'd0);
        chk("rst_out_err",   32'(ev_out_err),   32'd0);
        chk("rst_err_cnt",   32'(ev_err_cnt),   32'd0);
        chk("rst_busy",      32'(ev_busy),      32'd0);

        // A5 has four ones: parity 0 is clean in even mode, an error in odd mode.
        send(8'hA5, 1'b0, lat);
        chk("t1_latency", 32'(lat),        32'd9);
        chk("t1_err",     32'(ev_out_err), 32'd0);
        chk("t1_cnt",     32'(ev_err_cnt), 32'd0);
        chk("t1_odd_err", 32'(od_out_err), 32'd1);
        tick();
        chk("t1_idle_ready", 32'(ev_in_ready),  32'd1);
        chk("t1_idle_valid", 32'(ev_out_valid), 32'd0);

        send(8'hA5, 1'b1, lat);
        chk("t2_err",     32'(ev_out_err), 32'd1);
        chk("t2_cnt",     32'(ev_err_cnt), 32'd1);
        chk("t2_odd_err", 32'(od_out_err), 32'd0);
        tick();

        send(8'h07, 1'b0, lat);
        chk("t3_odd_err", 32'(od_out_err), 32'd0);
        chk("t3_err",     32'(ev_out_err), 32'd1);
        chk("t3_cnt",     32'(ev_err_cnt), 32'd2);
        tick();

        out_ready = 1'b0;
        send(8'h3C, 1'b0, lat);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 32'(ev_out_valid), 32'd1);
            chk("bp_err",   32'(ev_out_err),   32'd0);
            chk("bp_ready", 32'(ev_in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel_ready", 32'(ev_in_ready),  32'd1);
        chk("bp_rel_valid", 32'(ev_out_valid), 32'd0);

        // Three words with in_valid held high throughout.
        acc_q.delete();
        vrd_q.delete();
        in_data = w[0]; in_parity = wp[0]; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while (acc_q.size() <= i && t < 100) begin
                tick();
                t++;
            end
            if (i < 2) begin
                in_data = w[i+1];
                in_parity = wp[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        t = 0;
        while (vrd_q.size() < 3 && t < 100) begin
            tick();
            t++;
        end
        chk("b2b_n_acc", 32'(acc_q.size()), 32'd3);
        chk("b2b_n_vrd", 32'(vrd_q.size()), 32'd3);
        if (acc_q.size() == 3 && vrd_q.size() == 3) begin
            chk("b2b_gap0", 32'(acc_q[1] - acc_q[0]), 32'd11);
            chk("b2b_gap1", 32'(acc_q[2] - acc_q[1]), 32'd11);
            chk("b2b_v0",   32'(vrd_q[0]), 32'd0);
            chk("b2b_v1",   32'(vrd_q[1]), 32'd1);
            chk("b2b_v2",   32'(vrd_q[2]), 32'd0);
        end
        chk("b2b_cnt", 32'(ev_err_cnt), 32'd3);

        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_sat", 32'(sat_err_cnt), 32'd0);
        chk("clr_ev",  32'(ev_err_cnt),  32'd0);
        for (int k = 1; k <= 5; k++) begin
            send(8'hA5, 1'b1, lat);
            chk("sat_cnt", 32'(sat_err_cnt), (k > 3) ? 32'd3 : 32'(k));
            tick();
        end

        // Sixth erroneous word: clear lands on the same edge as the increment.
        in_data = 8'hA5; in_parity = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clrwin_valid", 32'(sat_out_valid), 32'd1);
        chk("clrwin_err",   32'(sat_out_err),   32'd1);
        chk("clrwin_sat",   32'(sat_err_cnt),   32'd0);
        chk("clrwin_ev",    32'(ev_err_cnt),    32'd0);
        tick();

        send(8'hA5, 1'b1, lat);
        chk("pre_rst_cnt", 32'(ev_err_cnt), 32'd1);
        tick();

        // 07 leaves the tracker ODD after four bits when reset strikes.
        in_data = 8'h07; in_parity = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mrst_busy",  32'(ev_busy),      32'd0);
        chk("mrst_valid", 32'(ev_out_valid), 32'd0);
        chk("mrst_cnt",   32'(ev_err_cnt),   32'd0);
        chk("mrst_ready", 32'(ev_in_ready),  32'd1);
        chk("mrst_sat",   32'(sat_err_cnt),  32'd0);
        send(8'h3C, 1'b0, lat);
        chk("post_latency", 32'(lat),        32'd9);
        chk("post_err",     32'(ev_out_err), 32'd0);
        chk("post_cnt",     32'(ev_err_cnt), 32'd0);
        chk("post_odd_err", 32'(od_out_err), 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
